rs232_rcv: RTL and testbench

//  RS232 receiver, 8N1 (8 data bits, no parity, 1 stop bit), LSB first; 25 MHz clk.

---
 rtl/rs232_pkg.sv | 22 ++
 rtl/rs232_sync.sv | 23 ++
 rtl/rs232_rcv.sv | 196 +++++++++++++++++++
 tb/tb_rs232_rcv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: bit-timing terminal counts, receiver state type and tick counter type.
// Used by both the transmitter and the receiver so that their bit timing always matches.
package rs232_pkg;

  typedef logic [11:0] tick_t;

  localparam tick_t LIMIT_FAST = 12'd217;
  localparam tick_t LIMIT_SLOW = 12'd1302;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Tick count at which the start bit is re-checked (middle of the bit).
  function automatic tick_t half_lim(input tick_t lim);
    return lim >> 1;
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial input (RxD, CTS, ...).
// Both flops reset to 1 so that a reset never looks like a falling edge.
module rs232_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability-filter chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rcv.sv
// RS232 8N1 receiver, LSB first, 115200/19200 bps from a 25 MHz clock, polled via rdy/done.
// Define RS232R_FERR_EN to add the sticky ferr output and the stop-bit break hold-off.
module rs232_rcv
  import rs232_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       fsel,
  input  logic       done,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ovr
`ifdef RS232R_FERR_EN
  ,
  output logic       ferr
`endif
);

  rx_state_t  state, state_nx;
  tick_t      tick, tick_nx;
  tick_t      lim, lim_nx;
  logic [3:0] bitcnt, bitcnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       load, load_nx;
  logic       rxs, rxs_d, fall;
  logic [7:0] data_nx;
  logic       rdy_nx, ovr_nx;
`ifdef RS232R_FERR_EN
  logic       brk, brk_nx;
  logic       ferr_set, ferr_nx;
`endif

  rs232_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxs)
  );

  assign fall = rxs_d & ~rxs;

  // Frame state machine: next state, counters and shift register.
  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    lim_nx    = lim;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    load_nx   = 1'b0;
`ifdef RS232R_FERR_EN
    brk_nx    = brk;
    ferr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        tick_nx = 12'd0;
        if (fall) begin
          state_nx = START;
          lim_nx   = fsel ? LIMIT_FAST : LIMIT_SLOW;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (tick == half_lim(lim)) begin
          tick_nx = 12'd0;
          if (!rxs) begin
            state_nx  = DATA;
            bitcnt_nx = 4'd0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          tick_nx = tick + 12'd1;
        end
      end
      DATA: begin
        if (tick == lim) begin
          tick_nx   = 12'd0;
          shreg_nx  = {rxs, shreg[7:1]};
          bitcnt_nx = bitcnt + 4'd1;
          if (bitcnt == 4'd7) begin
            state_nx = STOP;
          end else begin
            state_nx = DATA;
          end
        end else begin
          tick_nx = tick + 12'd1;
        end
      end
      STOP: begin
`ifdef RS232R_FERR_EN
        // After a bad stop bit, hold here until the line returns high (break).
        if (brk) begin
          if (rxs) begin
            state_nx = IDLE;
            brk_nx   = 1'b0;
          end else begin
            state_nx = STOP;
          end
        end else if (tick == lim) begin
          tick_nx = 12'd0;
          if (rxs) begin
            state_nx = IDLE;
            load_nx  = 1'b1;
          end else begin
            brk_nx   = 1'b1;
            ferr_set = 1'b1;
          end
        end else begin
          tick_nx = tick + 12'd1;
        end
`else
        if (tick == lim) begin
          tick_nx  = 12'd0;
          state_nx = IDLE;
          load_nx  = 1'b1;
        end else begin
          tick_nx = tick + 12'd1;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
        tick_nx  = 12'd0;
      end
    endcase
  end

  // CPU-facing flags; a completing byte takes priority over a simultaneous done.
  always_comb begin
    data_nx = data;
    rdy_nx  = rdy;
    ovr_nx  = ovr;
    if (load) begin
      data_nx = shreg;
      rdy_nx  = 1'b1;
      if (rdy && !done) begin
        ovr_nx = 1'b1;
      end else begin
        ovr_nx = ovr;
      end
    end else if (done) begin
      rdy_nx = 1'b0;
      ovr_nx = 1'b0;
    end else begin
      rdy_nx = rdy;
    end
`ifdef RS232R_FERR_EN
    if (ferr_set) begin
      ferr_nx = 1'b1;
    end else if (done) begin
      ferr_nx = 1'b0;
    end else begin
      ferr_nx = ferr;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tick   <= 12'd0;
      lim    <= LIMIT_SLOW;
      bitcnt <= 4'd0;
      shreg  <= 8'h00;
      load   <= 1'b0;
      rxs_d  <= 1'b1;
      data   <= 8'h00;
      rdy    <= 1'b0;
      ovr    <= 1'b0;
`ifdef RS232R_FERR_EN
      brk    <= 1'b0;
      ferr   <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      tick   <= tick_nx;
      lim    <= lim_nx;
      bitcnt <= bitcnt_nx;
      shreg  <= shreg_nx;
      load   <= load_nx;
      rxs_d  <= rxs;
      data   <= data_nx;
      rdy    <= rdy_nx;
      ovr    <= ovr_nx;
`ifdef RS232R_FERR_EN
      brk    <= brk_nx;
      ferr   <= ferr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_rcv.sv
// Scoreboard bench for rs232_rcv: directed frames push expected {data, ovr}; a monitor checks each delivery.
module tb_rs232_rcv;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       fsel;
  logic       done;
  logic [7:0] data;
  logic       rdy;
  logic       ovr;
`ifdef RS232R_FERR_EN
  logic       ferr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  logic [8:0] q[$];

  rs232_rcv dut (
    .clk  (clk),
    .rst  (rst),
    .RxD  (rxd),
    .fsel (fsel),
    .done (done),
    .data (data),
    .rdy  (rdy),
    .ovr  (ovr)
`ifdef RS232R_FERR_EN
    ,
    .ferr (ferr)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a new delivery is a rising rdy, a data change while rdy, or a rising ovr.
  initial begin
    logic pr_rdy;
    logic pr_ovr;
    logic [7:0] pr_data;
    logic [8:0] e;
    pr_rdy = 1'b0;
    pr_ovr = 1'b0;
    pr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ((rdy && !pr_rdy) || (rdy && data != pr_data) || (ovr && !pr_ovr))) begin
        if (rdy && !pr_rdy) rise_cyc = cyc;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got data %0h ovr %0b, none expected", data, ovr);
        end else begin
          e = q.pop_front();
          chk("sb_data", {24'd0, data}, {24'd0, e[8:1]});
          chk("sb_ovr", {31'd0, ovr}, {31'd0, e[0]});
        end
      end
      pr_rdy = rdy;
      pr_ovr = ovr;
      pr_data = data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_bit);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (per) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (per) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, got %0d pending expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rxd = 1'b1;
    fsel = 1'b1;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_ovr", {31'd0, ovr}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: fast 0x55, latency near 9*218+108+3
    q.push_back({8'h55, 1'b0});
    send_byte(8'h55, 218, 1'b1);
    wait_drain("t1", 500);
    chk("t1_latency_ok", {31'd0, ((rise_cyc - start_cyc) >= 2065) && ((rise_cyc - start_cyc) <= 2085)}, 32'd1);
    pulse_done();
    chk("t1_done_rdy", {31'd0, rdy}, 32'd0);

    // 2: slow 0xA3, done clears rdy next clock; done with rdy=0 is harmless
    fsel = 1'b0;
    q.push_back({8'hA3, 1'b0});
    send_byte(8'hA3, 1303, 1'b1);
    wait_drain("t2", 2000);
    chk("t2_rdy", {31'd0, rdy}, 32'd1);
    pulse_done();
    chk("t2_done_rdy", {31'd0, rdy}, 32'd0);
    pulse_done();
    chk("t2_idle_done_rdy", {31'd0, rdy}, 32'd0);
    chk("t2_idle_done_data", {24'd0, data}, 32'hA3);

    // 3: 100-clk glitch is rejected as a false start
    fsel = 1'b1;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (600) @(negedge clk);
    chk("t3_glitch_rdy", {31'd0, rdy}, 32'd0);
    chk("t3_glitch_data", {24'd0, data}, 32'hA3);

    // 4: back-to-back bytes without done -> overrun
    q.push_back({8'h12, 1'b0});
    q.push_back({8'h34, 1'b1});
    send_byte(8'h12, 218, 1'b1);
    send_byte(8'h34, 218, 1'b1);
    wait_drain("t4", 500);
    chk("t4_rdy", {31'd0, rdy}, 32'd1);
    pulse_done();
    chk("t4_done_rdy", {31'd0, rdy}, 32'd0);
    chk("t4_done_ovr", {31'd0, ovr}, 32'd0);

    // 5: reset mid-frame of 0xFF, then clean 0x0F
    rxd = 1'b0;
    repeat (218) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * 218) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_data", {24'd0, data}, 32'h00);
    chk("t5_rst_rdy", {31'd0, rdy}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    q.push_back({8'h0F, 1'b0});
    send_byte(8'h0F, 218, 1'b1);
    wait_drain("t5", 500);
    pulse_done();

    // 6: bad stop bit on 0x7E
`ifdef RS232R_FERR_EN
    send_byte(8'h7E, 218, 1'b0);
    repeat (50) @(negedge clk);
    chk("t6_ferr", {31'd0, ferr}, 32'd1);
    chk("t6_rdy", {31'd0, rdy}, 32'd0);
    chk("t6_data", {24'd0, data}, 32'h0F);
    pulse_done();
    chk("t6_ferr_clr", {31'd0, ferr}, 32'd0);
`else
    q.push_back({8'h7E, 1'b0});
    send_byte(8'h7E, 218, 1'b0);
    wait_drain("t6", 500);
    chk("t6_rdy", {31'd0, rdy}, 32'd1);
    pulse_done();
`endif
    repeat (20) @(negedge clk);

    // 7: +/-2% baud skew
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = (k == 0) ? 8'h00 : ((k == 1) ? 8'hFF : 8'hA5);
      q.push_back({b, 1'b0});
      send_byte(b, 222, 1'b1);
      wait_drain("t7_slow", 500);
      pulse_done();
      q.push_back({b ^ 8'h5A, 1'b0});
      send_byte(b ^ 8'h5A, 214, 1'b1);
      wait_drain("t7_fast", 500);
      pulse_done();
    end

    repeat (20) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
